// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV64 core. It holds under back-pressure, inserts one bubble
// on a load-use hazard, squashes on redirect, and counts load-use bubbles.
module id_ex_stage #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [31:0]      id_inst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_we_reg,
   input  logic             id_re_mem,
   input  logic             id_we_mem,
   input  logic [3:0]       id_alu_op,
   input  logic [XLEN-1:0]  id_rs1_val,
   input  logic [XLEN-1:0]  id_rs2_val,
   input  logic [XLEN-1:0]  id_imm,
   input  logic             ex_ready,
   input  logic             flush,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [31:0]      ex_inst,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic             ex_use_rs1,
   output logic             ex_use_rs2,
   output logic             ex_we_reg,
   output logic             ex_re_mem,
   output logic             ex_we_mem,
   output logic [3:0]       ex_alu_op,
   output logic [XLEN-1:0]  ex_rs1_val,
   output logic [XLEN-1:0]  ex_rs2_val,
   output logic [XLEN-1:0]  ex_imm,
   output logic             load_use,
   output logic             id_stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   logic             valid_reg, valid_next;
   logic [XLEN-1:0]  pc_reg, pc_next;
   logic [31:0]      inst_reg, inst_next;
   logic [4:0]       rs1_reg, rs1_next;
   logic [4:0]       rs2_reg, rs2_next;
   logic [4:0]       rd_reg, rd_next;
   logic             use_rs1_reg, use_rs1_next;
   logic             use_rs2_reg, use_rs2_next;
   logic             we_reg_reg, we_reg_next;
   logic             re_mem_reg, re_mem_next;
   logic             we_mem_reg, we_mem_next;
   logic [3:0]       alu_op_reg, alu_op_next;
   logic [XLEN-1:0]  rs1_val_reg, rs1_val_next;
   logic [XLEN-1:0]  rs2_val_reg, rs2_val_next;
   logic [XLEN-1:0]  imm_reg, imm_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic rs1_hit;
   logic rs2_hit;

   // Only a load in EX writing a non-zero register can outrun forwarding.
   assign rs1_hit  = id_use_rs1 && (id_rs1 == rd_reg);
   assign rs2_hit  = id_use_rs2 && (id_rs2 == rd_reg);
   assign load_use = id_valid && valid_reg && re_mem_reg && (rd_reg != 5'd0) && (rs1_hit || rs2_hit);
   assign id_stall = !flush && (load_use || !ex_ready);

   always_comb begin
      valid_next   = valid_reg;
      pc_next      = pc_reg;
      inst_next    = inst_reg;
      rs1_next     = rs1_reg;
      rs2_next     = rs2_reg;
      rd_next      = rd_reg;
      use_rs1_next = use_rs1_reg;
      use_rs2_next = use_rs2_reg;
      we_reg_next  = we_reg_reg;
      re_mem_next  = re_mem_reg;
      we_mem_next  = we_mem_reg;
      alu_op_next  = alu_op_reg;
      rs1_val_next = rs1_val_reg;
      rs2_val_next = rs2_val_reg;
      imm_next     = imm_reg;
      if (flush || (ex_ready && load_use)) begin
         valid_next   = 1'b0;
         pc_next      = '0;
         inst_next    = '0;
         rs1_next     = '0;
         rs2_next     = '0;
         rd_next      = '0;
         use_rs1_next = 1'b0;
         use_rs2_next = 1'b0;
         we_reg_next  = 1'b0;
         re_mem_next  = 1'b0;
         we_mem_next  = 1'b0;
         alu_op_next  = '0;
         rs1_val_next = '0;
         rs2_val_next = '0;
         imm_next     = '0;
      end else if (ex_ready) begin
         valid_next   = id_valid;
         pc_next      = id_pc;
         inst_next    = id_inst;
         rs1_next     = id_rs1;
         rs2_next     = id_rs2;
         rd_next      = id_rd;
         use_rs1_next = id_use_rs1;
         use_rs2_next = id_use_rs2;
         we_reg_next  = id_we_reg && id_valid;
         re_mem_next  = id_re_mem && id_valid;
         we_mem_next  = id_we_mem && id_valid;
         alu_op_next  = id_alu_op;
         rs1_val_next = id_rs1_val;
         rs2_val_next = id_rs2_val;
         imm_next     = id_imm;
      end
   end

   // Flush bubbles are deliberately not counted; only hazard bubbles are.
   always_comb begin
      cnt_next = cnt_reg;
      if (!flush && ex_ready && load_use && (cnt_reg != {CNT_W{1'b1}}))
         cnt_next = cnt_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_reg   <= 1'b0;
         pc_reg      <= '0;
         inst_reg    <= '0;
         rs1_reg     <= '0;
         rs2_reg     <= '0;
         rd_reg      <= '0;
         use_rs1_reg <= 1'b0;
         use_rs2_reg <= 1'b0;
         we_reg_reg  <= 1'b0;
         re_mem_reg  <= 1'b0;
         we_mem_reg  <= 1'b0;
         alu_op_reg  <= '0;
         rs1_val_reg <= '0;
         rs2_val_reg <= '0;
         imm_reg     <= '0;
         cnt_reg     <= '0;
      end else begin
         valid_reg   <= valid_next;
         pc_reg      <= pc_next;
         inst_reg    <= inst_next;
         rs1_reg     <= rs1_next;
         rs2_reg     <= rs2_next;
         rd_reg      <= rd_next;
         use_rs1_reg <= use_rs1_next;
         use_rs2_reg <= use_rs2_next;
         we_reg_reg  <= we_reg_next;
         re_mem_reg  <= re_mem_next;
         we_mem_reg  <= we_mem_next;
         alu_op_reg  <= alu_op_next;
         rs1_val_reg <= rs1_val_next;
         rs2_val_reg <= rs2_val_next;
         imm_reg     <= imm_next;
         cnt_reg     <= cnt_next;
      end
   end

   assign ex_valid   = valid_reg;
   assign ex_pc      = pc_reg;
   assign ex_inst    = inst_reg;
   assign ex_rs1     = rs1_reg;
   assign ex_rs2     = rs2_reg;
   assign ex_rd      = rd_reg;
   assign ex_use_rs1 = use_rs1_reg;
   assign ex_use_rs2 = use_rs2_reg;
   assign ex_we_reg  = we_reg_reg;
   assign ex_re_mem  = re_mem_reg;
   assign ex_we_mem  = we_mem_reg;
   assign ex_alu_op  = alu_op_reg;
   assign ex_rs1_val = rs1_val_reg;
   assign ex_rs2_val = rs2_val_reg;
   assign ex_imm     = imm_reg;
   assign bubble_cnt = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: advance, load-use bubble, false-stall cases,
// back-pressure hold, flush priority, async reset and counter saturation.
module tb_id_ex_stage;

   localparam int XLEN  = 64;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rstn;
   logic             id_valid;
   logic [XLEN-1:0]  id_pc;
   logic [31:0]      id_inst;
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic             id_use_rs1, id_use_rs2;
   logic             id_we_reg, id_re_mem, id_we_mem;
   logic [3:0]       id_alu_op;
   logic [XLEN-1:0]  id_rs1_val, id_rs2_val, id_imm;
   logic             ex_ready, flush;
   logic             ex_valid;
   logic [XLEN-1:0]  ex_pc;
   logic [31:0]      ex_inst;
   logic [4:0]       ex_rs1, ex_rs2, ex_rd;
   logic             ex_use_rs1, ex_use_rs2;
   logic             ex_we_reg, ex_re_mem, ex_we_mem;
   logic [3:0]       ex_alu_op;
   logic [XLEN-1:0]  ex_rs1_val, ex_rs2_val, ex_imm;
   logic             load_use, id_stall;
   logic [CNT_W-1:0] bubble_cnt;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn),
      .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_we_reg(id_we_reg), .id_re_mem(id_re_mem), .id_we_mem(id_we_mem),
      .id_alu_op(id_alu_op), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
      .ex_ready(ex_ready), .flush(flush),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2),
      .ex_we_reg(ex_we_reg), .ex_re_mem(ex_re_mem), .ex_we_mem(ex_we_mem),
      .ex_alu_op(ex_alu_op), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
      .load_use(load_use), .id_stall(id_stall), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                         input logic u2, input logic wr, input logic rm, input logic [63:0] v1);
      id_valid   = v;
      id_pc      = pc;
      id_inst    = pc[31:0] ^ 32'h0000_0013;
      id_rs1     = rs1;
      id_rs2     = rs2;
      id_rd      = rd;
      id_use_rs1 = u1;
      id_use_rs2 = u2;
      id_we_reg  = wr;
      id_re_mem  = rm;
      id_we_mem  = 1'b0;
      id_alu_op  = 4'd0;
      id_rs1_val = v1;
      id_rs2_val = 64'h22;
      id_imm     = 64'h8;
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      ex_ready = 1'b1;
      flush = 1'b0;
      set_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      tick();
      tick();
      check("reset_ex_valid", {63'd0, ex_valid}, 64'd0);
      check("reset_ex_pc", ex_pc, 64'd0);
      check("reset_bubble_cnt", {60'd0, bubble_cnt}, 64'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Plain advance
      set_id(1'b1, 64'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 64'h11);
      check("adv_id_stall_pre", {63'd0, id_stall}, 64'd0);
      tick();
      check("adv_ex_valid", {63'd0, ex_valid}, 64'd1);
      check("adv_ex_pc", ex_pc, 64'h100);
      check("adv_ex_rd", {59'd0, ex_rd}, 64'd5);
      check("adv_ex_we_reg", {63'd0, ex_we_reg}, 64'd1);
      check("adv_id_stall", {63'd0, id_stall}, 64'd0);

      // Load-use: ld x5 then add x6,x5,x1
      set_id(1'b1, 64'h104, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
      check("ld_enter_no_hazard", {63'd0, load_use}, 64'd0);
      tick();
      set_id(1'b1, 64'h108, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 64'hAAAA);
      check("lu_load_use", {63'd0, load_use}, 64'd1);
      check("lu_id_stall", {63'd0, id_stall}, 64'd1);
      tick();
      check("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
      check("lu_bubble_rd", {59'd0, ex_rd}, 64'd0);
      check("lu_bubble_pc", ex_pc, 64'd0);
      check("lu_bubble_we_reg", {63'd0, ex_we_reg}, 64'd0);
      check("lu_bubble_cnt", {60'd0, bubble_cnt}, 64'd1);
      set_id(1'b1, 64'h108, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 64'hBBBB);
      check("lu_stall_released", {63'd0, id_stall}, 64'd0);
      tick();
      check("lu_issue_valid", {63'd0, ex_valid}, 64'd1);
      check("lu_issue_pc", ex_pc, 64'h108);
      check("lu_issue_rs1_val", ex_rs1_val, 64'hBBBB);
      check("lu_issue_cnt", {60'd0, bubble_cnt}, 64'd1);

      // Load to x0 never stalls
      set_id(1'b1, 64'h10C, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
      tick();
      set_id(1'b1, 64'h110, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0);
      check("ldx0_no_stall", {63'd0, load_use}, 64'd0);
      tick();
      // ld x5 in EX, rs2 matches but is unused
      set_id(1'b1, 64'h114, 5'd3, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
      check("unused_rs2_no_stall", {63'd0, load_use}, 64'd0);
      check("unused_rs2_id_stall", {63'd0, id_stall}, 64'd0);
      id_use_rs2 = 1'b1;
      #1;
      check("used_rs2_stall", {63'd0, load_use}, 64'd1);
      id_use_rs2 = 1'b0;
      #1;
      tick();
      check("nofalse_ex_pc", ex_pc, 64'h114);
      check("nofalse_cnt", {60'd0, bubble_cnt}, 64'd1);

      // Back-pressure for 3 cycles
      ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 64'h200 + 64'(4 * i), 5'd1, 5'd2, 5'(8 + i), 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
         check("bp_id_stall", {63'd0, id_stall}, 64'd1);
         tick();
         check("bp_hold_pc", ex_pc, 64'h114);
         check("bp_hold_rd", {59'd0, ex_rd}, 64'd7);
      end
      ex_ready = 1'b1;
      set_id(1'b1, 64'h300, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
      check("bp_release_stall", {63'd0, id_stall}, 64'd0);
      tick();
      check("bp_take_pc", ex_pc, 64'h300);
      check("bp_take_rd", {59'd0, ex_rd}, 64'd12);

      // Flush beats load-use and back-pressure
      set_id(1'b1, 64'h304, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
      tick();
      set_id(1'b1, 64'h308, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
      ex_ready = 1'b0;
      flush = 1'b1;
      #1;
      check("fl_load_use", {63'd0, load_use}, 64'd1);
      check("fl_id_stall", {63'd0, id_stall}, 64'd0);
      tick();
      check("fl_ex_valid", {63'd0, ex_valid}, 64'd0);
      check("fl_ex_we_reg", {63'd0, ex_we_reg}, 64'd0);
      check("fl_cnt", {60'd0, bubble_cnt}, 64'd1);
      flush = 1'b0;
      ex_ready = 1'b1;

      // Asynchronous reset mid-cycle
      set_id(1'b1, 64'h400, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0);
      tick();
      check("pre_rst_valid", {63'd0, ex_valid}, 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst_valid", {63'd0, ex_valid}, 64'd0);
      check("async_rst_pc", ex_pc, 64'd0);
      check("async_rst_re_mem", {63'd0, ex_re_mem}, 64'd0);
      check("async_rst_rd", {59'd0, ex_rd}, 64'd0);
      check("async_rst_cnt", {60'd0, bubble_cnt}, 64'd0);
      check("async_rst_load_use", {63'd0, load_use}, 64'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Saturation: 20 load-use bubbles from zero
      for (int i = 0; i < 20; i++) begin
         tick();
         check("sat_hazard", {63'd0, load_use}, 64'd1);
         tick();
         if (i == 4)
            check("sat_cnt_5", {60'd0, bubble_cnt}, 64'd5);
      end
      check("sat_cnt_final", {60'd0, bubble_cnt}, 64'd15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the 5-stage RV64 core: registers decoded ID-stage fields into the EX stage and detects load-use hazards that forwarding cannot cover. It inserts one bubble, holds under back-pressure, and squashes on branch redirect. Its registered `ex_*` outputs supply the EX-stage operand mux and the rs1/rs2/rd/write-enable inputs of the forwarding unit. A saturating counter tracks bubbles inserted.

## Interface
- `XLEN`, 64, data/PC width
- `CNT_W`, 32, bubble-counter width
- `clk`  in  1  core clock; all state updates on rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `id_valid`  in  1  ID holds a real instruction
- `id_pc`  in  XLEN  ID instruction PC
- `id_inst`  in  32  ID instruction word
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices
- `id_use_rs1`, `id_use_rs2`  in  1 each  instruction actually reads rs1/rs2
- `id_we_reg`, `id_re_mem`, `id_we_mem`  in  1 each  decoded controls
- `id_alu_op`  in  4  ALU operation
- `id_rs1_val`, `id_rs2_val`, `id_imm`  in  XLEN each  register-file reads, immediate
- `ex_ready`  in  1  EX/MEM can accept; low = downstream stall
- `flush`  in  1  branch/jump redirect resolved in EX; kill ID→EX transfer
- `ex_valid`, `ex_pc`, `ex_inst`, `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_use_rs1`, `ex_use_rs2`, `ex_we_reg`, `ex_re_mem`, `ex_we_mem`, `ex_alu_op`, `ex_rs1_val`, `ex_rs2_val`, `ex_imm`  out  same widths as `id_*` counterparts  registered EX-stage fields
- `load_use`  out  1  combinational; load-use hazard this cycle
- `id_stall`  out  1  combinational; IF/ID and PC must hold
- `bubble_cnt`  out  CNT_W  bubbles inserted, saturating

## Operation
- Hazard detection:
  - `load_use = id_valid & ex_valid & ex_re_mem & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))`.
- Stall output:
  - `id_stall = ~flush & (load_use | ~ex_ready)`.
- Per-edge action, in priority order:
  - 1. Reset: all outputs zero.
  - 2. `flush`: load a bubble.
  - 3. `~ex_ready`: hold all `ex_*` registers unchanged.
  - 4. `load_use`: load a bubble.
  - 5. Otherwise: advance by copying every `id_*` field to `ex_*`. `ex_valid = id_valid`. Controls are gated: `ex_we_reg`, `ex_re_mem` and `ex_we_mem` are ANDed with `id_valid`.
- A bubble means all `ex_*` outputs are zero. In particular, valid, write enables and rd are 0, so the forwarding unit never matches a bubble.
- `bubble_cnt` increments by 1 on each edge that loads a bubble under `load_use`, not `flush`.
  - It saturates at all-ones.
  - Flush bubbles are not counted.
- Stalled ID instruction: ID re-presents it with freshly read register values. No operand values are captured while stalled.
- Load to x0 never stalls.
- A non-load producer in EX never stalls; forwarding covers it.

## Timing
- Output latency: `ex_*` outputs change only after a rising edge, one cycle after the corresponding `id_*` inputs.
- Hazard outputs: `load_use` and `id_stall` are same-cycle combinational outputs from current `ex_*` and `id_*`.
- Load-use stall length: exactly one cycle. After the bubble, `ex_re_mem = 0`, so the stalled instruction issues next cycle. Its load operand then comes from MEM/WB forwarding.
- `ex_ready` low for N cycles:
  - `ex_*` are held for N edges.
  - `id_stall` stays high for those N cycles.
  - `load_use` may be high during that time, but no bubble is inserted while holding. A pending hazard resolves once `ex_ready` rises.
- `flush` together with `load_use` or `~ex_ready`: flush wins. A bubble is loaded, `id_stall = 0`, and the counter does not increment.
- Reset asserted mid-operation: all outputs clear immediately, independent of `clk`.
- After reset release: the first edge with `id_valid = 1` and no hazard sets `ex_valid = 1`.

## Test plan
- Advance: `id_valid = 1`, `id_pc = 0x100`, `id_rd = 5`, `id_we_reg = 1`, `ex_ready = 1`. After one edge: `ex_valid = 1`, `ex_pc = 0x100`, `ex_rd = 5`, `id_stall = 0`.
- Load-use:
  - Stimulus: `ld x5` is in EX (`ex_re_mem = 1`, `ex_rd = 5`). ID holds `add x6,x5,x1` with `id_use_rs1 = 1`, `id_rs1 = 5`.
  - Required response: `load_use = 1` and `id_stall = 1` for exactly one cycle. The next edge yields an all-zero EX. The following edge issues the add. `bubble_cnt` goes 0→1.
- No false stall, two cases:
  - `ld x0` in EX with `id_rs1 = 0` gives `load_use = 0`.
  - `ld x5` in EX with `id_rs2 = 5` and `id_use_rs2 = 0` gives `load_use = 0`.
- Back-pressure: `ex_ready = 0` for 3 cycles with new `id_*` values each cycle. `ex_*` stay constant, `id_stall = 1` for 3 cycles, and EX takes the current ID fields on the 4th edge.
- Flush priority: `flush = 1` concurrent with both `load_use = 1` and `ex_ready = 0`. Next edge gives `ex_valid = 0` and `ex_we_reg = 0`; `id_stall = 0` and `bubble_cnt` unchanged.
- Reset and saturation:
  - With `CNT_W = 4`, 20 consecutive load-use bubbles leave `bubble_cnt = 15`.
  - Dropping `rstn` mid-cycle zeroes all outputs before the next edge.
